reg_file_wb_pipe: RTL
=====================

Name: reg_file_wb_pipe

Overview:
Parametrised register file with a registered write-back stage. It is the next generation of the combinational register-file input muxing. It selects the write-back value (ALU, memory, SP, PC+1) and optionally merges in a half-word from a fixed register. It holds the result in one pending stage, commits it to the register array, and forwards pending data to two combinational read ports. It sits between the execute/memory stages and the operand fetch of the processor datapath.

Parameters:
DATA_W, 16, register/data width in bits; must be even
ADDR_W, 3, register address width; array holds 2**ADDR_W registers
MERGE_REG, 5, index of the register supplying the upper half in merge mode
ZERO_HARDWIRED, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  freeze write-back pipeline (no capture, no commit)
wb_valid  in  1  write-back request this cycle
wb_dst  in  ADDR_W  destination register
wb_sel  in  2  value source: 0 alu_out, 1 mem_out, 2 sp_addr, 3 pc+1
wb_merge  in  1  half-word merge mode
alu_out  in  DATA_W  ALU result
mem_out  in  DATA_W  memory read data
sp_addr  in  DATA_W  stack pointer address
pc  in  DATA_W  current PC
rd_a_addr  in  ADDR_W  read port A address
rd_b_addr  in  ADDR_W  read port B address
rd_a_data  out  DATA_W  read port A data (combinational)
rd_b_data  out  DATA_W  read port B data (combinational)
pend_valid  out  1  pending stage holds an uncommitted write
pend_dst  out  ADDR_W  destination of pending write

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high, and overrides stall.
- Reset values: all registers 0, pend_valid 0, pend_dst 0, pending value 0. A pending write at reset is discarded, not committed.
- Source value: selected by wb_sel. pc+1 is computed in DATA_W bits and wraps: pc = all-ones gives 0.
- Merge: H = DATA_W/2. When wb_merge = 1, value = {M[H-1:0], src[DATA_W-1:H]}. M is the current forwarded content of MERGE_REG (see forwarding rule).
- Capture: at an edge with rst = 0 and stall = 0, the pending stage loads wb_valid, wb_dst and the computed value. If wb_valid = 0, pend_valid becomes 0 (dst/value don't-care).
- Commit: at the same edge (rst = 0, stall = 0), if pend_valid = 1, write the pending value to reg[pend_dst]. Capture and commit happen on the same edge. Latency from request to array write is 2 edges; to read-port visibility it is 1 edge (via forwarding).
- Stall: while stall = 1 the pending stage and the array hold unchanged. The wb_* inputs presented during a stall are dropped; the producer must hold them.
- Forwarding: a read of address X (port A, port B, or the internal MERGE_REG read) returns the pending value if pend_valid = 1 and pend_dst = X; otherwise it returns reg[X].
- ZERO_HARDWIRED = 1: reads of address 0 return 0 regardless of forwarding; commits to 0 are suppressed.
- ZERO_HARDWIRED = 0: register 0 is an ordinary register.
- Back-to-back writes to the same register: the newer value is forwarded once captured. The older value is committed on that same edge and the newer one on the next, so the final array content is the newest value.
- Both read ports may address the same register; each resolves independently.

Test Plan:
- Reset, then read all 8 addresses -> all 0, pend_valid 0. Assert rst with a pending write to r3 = 0x1234 -> r3 stays 0.
- wb_valid, dst 2, sel 0, alu_out 0xBEEF; rd_a_addr 2 -> rd_a_data 0 before the edge, 0xBEEF after edge 1 (forwarded), still 0xBEEF after edge 2 (array).
- sel 3, pc 0xFFFF, dst 4 -> r4 = 0x0000 (wrap). sel 3, pc 0x0010 -> 0x0011.
- r5 = 0x00AB; merge, sel 1, mem_out 0x12CD, dst 1 -> r1 = 0xAB12. Repeat immediately after a pending write r5 = 0x0077 -> merge uses 0x77 via forwarding, giving 0x7712.
- stall = 1 for 3 cycles with a pending write to r6 = 0x5555 -> pend_valid stays 1, array r6 unchanged, rd_b (addr 6) reads 0x5555 throughout. Release -> committed.
- ZERO_HARDWIRED = 1: write r0 = 0xFFFF -> rd_a(0) = 0 at every cycle. Back-to-back writes r7 = 1 then r7 = 2 -> r7 reads 1, then 2, final array value 2.

Source files
------------

// File: rtl/reg_file_wb_pipe.sv
// Register file with one registered write-back stage, half-word merge and
// forwarding of the pending write to both combinational read ports.
module reg_file_wb_pipe #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned MERGE_REG      = 5,
  parameter int unsigned ZERO_HARDWIRED = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_wb_valid,
  input  logic [ADDR_W-1:0] i_wb_dst,
  input  logic [1:0]        i_wb_sel,
  input  logic              i_wb_merge,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic [DATA_W-1:0] i_mem_out,
  input  logic [DATA_W-1:0] i_sp_addr,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_rd_a_addr,
  input  logic [ADDR_W-1:0] i_rd_b_addr,
  output logic [DATA_W-1:0] o_rd_a_data,
  output logic [DATA_W-1:0] o_rd_b_data,
  output logic              o_pend_valid,
  output logic [ADDR_W-1:0] o_pend_dst
);

  localparam int unsigned       NREG       = 2 ** ADDR_W;
  localparam int unsigned       HALF_W     = DATA_W / 2;
  localparam logic [ADDR_W-1:0] MERGE_ADDR = ADDR_W'(MERGE_REG);
  localparam bit                ZERO_HW    = (ZERO_HARDWIRED != 0);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_dst;
  logic [DATA_W-1:0] r_pend_data;

  logic [DATA_W-1:0] w_src;
  logic [DATA_W-1:0] w_merge_rd;
  logic [DATA_W-1:0] w_wb_value;
  logic              w_commit;

  // Pending write wins over the array; a hardwired r0 wins over both.
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arr_data
  );
    if (ZERO_HW && (addr == '0))
      return '0;
    else if (r_pend_valid && (r_pend_dst == addr))
      return r_pend_data;
    else
      return arr_data;
  endfunction

  assign o_rd_a_data = fwd_read(i_rd_a_addr, r_regs[i_rd_a_addr]);
  assign o_rd_b_data = fwd_read(i_rd_b_addr, r_regs[i_rd_b_addr]);
  assign w_merge_rd  = fwd_read(MERGE_ADDR, r_regs[MERGE_ADDR]);

  always_comb begin
    w_src = i_alu_out;
    case (i_wb_sel)
      2'd0: w_src = i_alu_out;
      2'd1: w_src = i_mem_out;
      2'd2: w_src = i_sp_addr;
      2'd3: w_src = i_pc + DATA_W'(1);
      default: w_src = i_alu_out;
    endcase
  end

  // Merge places the low half of MERGE_REG on top of the source's high half.
  assign w_wb_value = i_wb_merge ? {w_merge_rd[HALF_W-1:0], w_src[DATA_W-1:HALF_W]} : w_src;

  assign w_commit = r_pend_valid && !(ZERO_HW && (r_pend_dst == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
      r_pend_valid <= 1'b0;
      r_pend_dst   <= '0;
      r_pend_data  <= '0;
    end else if (!i_stall) begin
      if (w_commit) r_regs[r_pend_dst] <= r_pend_data;
      r_pend_valid <= i_wb_valid;
      r_pend_dst   <= i_wb_dst;
      r_pend_data  <= w_wb_value;
    end
  end

  assign o_pend_valid = r_pend_valid;
  assign o_pend_dst   = r_pend_dst;

endmodule
